debounce_multi: RTL

Multi-channel, parametrised debouncer for mechanical buttons and switches. Each channel synchronises its raw input, requires it to be stable for a programmable number of milliseconds, and then updates a clean level output. It also raises one-cycle rise/fall strobes and, optionally, a long-press strobe. It sits between the board pins and the traffic-light control FSM, replacing per-button single-channel instances with one shared millisecond prescaler.

---
 rtl/debounce_multi.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel switch/button debouncer with one shared millisecond prescaler.
// Define DEBOUNCE_LONGPRESS_EN to build the per-channel long-press strobe; otherwise long is tied low.
module debounce_multi #(
    parameter int C_CHANNELS    = 4,
    parameter int C_CLK_FRQ     = 100_000_000,
    parameter int C_INTERVAL_MS = 10,
    parameter int C_LONG_MS     = 1000
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [C_CHANNELS-1:0] in,
    output logic [C_CHANNELS-1:0] out,
    output logic [C_CHANNELS-1:0] rise,
    output logic [C_CHANNELS-1:0] fall,
    output logic [C_CHANNELS-1:0] long
);

    localparam int C_TICK = C_CLK_FRQ / 1000;
    localparam int C_PW   = (C_TICK > 1) ? $clog2(C_TICK) : 1;
    localparam int C_CW   = $clog2(C_INTERVAL_MS + 1);

    localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(C_TICK - 1);
    localparam logic [C_CW-1:0] C_CNT_LAST   = C_CW'(C_INTERVAL_MS - 1);

    generate
        if (C_CHANNELS < 1 || C_TICK < 1 || C_INTERVAL_MS < 1 || C_LONG_MS < 1) begin : g_bad_param
            $error("debounce_multi: parameter out of range");
        end
    endgenerate

    // Shared millisecond prescaler
    logic [C_PW-1:0] presc_q;
    logic [C_PW-1:0] presc_d;
    logic            tick;

    always_comb begin
        tick    = (presc_q == C_PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic [C_CHANNELS-1:0] s1_q;
    logic [C_CHANNELS-1:0] s_q;
    logic [C_CHANNELS-1:0] out_q;
    logic [C_CHANNELS-1:0] out_d;
    logic [C_CHANNELS-1:0] rise_q;
    logic [C_CHANNELS-1:0] rise_d;
    logic [C_CHANNELS-1:0] fall_q;
    logic [C_CHANNELS-1:0] fall_d;
    logic [C_CW-1:0]       cnt_q [C_CHANNELS];
    logic [C_CW-1:0]       cnt_d [C_CHANNELS];

    // A synchronised level that agrees with out restarts the interval on every cycle.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == C_CNT_LAST) begin
                    out_d[i]  = s_q[i];
                    rise_d[i] = s_q[i];
                    fall_d[i] = ~s_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            s1_q   <= '0;
            s_q    <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < C_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= in;
            s_q    <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < C_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int C_LW = $clog2(C_LONG_MS + 1);

    localparam logic [C_LW-1:0] C_LC_MAX  = C_LW'(C_LONG_MS);
    localparam logic [C_LW-1:0] C_LC_LAST = C_LW'(C_LONG_MS - 1);

    logic [C_LW-1:0]       lc_q [C_CHANNELS];
    logic [C_LW-1:0]       lc_d [C_CHANNELS];
    logic [C_CHANNELS-1:0] long_q;
    logic [C_CHANNELS-1:0] long_d;

    // Saturating at the threshold makes the strobe fire once per press.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            lc_d[i] = lc_q[i];
            if (!out_q[i]) begin
                lc_d[i] = '0;
            end else if (tick && (lc_q[i] != C_LC_MAX)) begin
                lc_d[i]   = lc_q[i] + 1'b1;
                long_d[i] = (lc_q[i] == C_LC_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            long_q <= '0;
            for (int i = 0; i < C_CHANNELS; i++) begin
                lc_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int i = 0; i < C_CHANNELS; i++) begin
                lc_q[i] <= lc_d[i];
            end
        end
    end

    assign long = long_q;
`else
    assign long = '0;
`endif

endmodule
